// File: rtl/cw305_reg_master_pkg.sv
// rtl/cw305_reg_master_pkg.sv - shared types and constants for the CW305 register-bus master
package cw305_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RREQ,
    ST_RWAIT,
    ST_RHOLD,
    ST_GAP
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;
  localparam int LAT_CNT_W    = 2;

  localparam int STAT_BYTES_W = 32;
  localparam int STAT_CMDS_W  = 16;

endpackage

// File: rtl/cw305_reg_master_if.sv
// rtl/cw305_reg_master_if.sv - command, byte-stream and register-bus signals of the CW305 bus master
interface cw305_reg_master_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 8
);
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [AW-1:0]            cmd_addr;
  logic [pBYTECNT_SIZE-1:0] cmd_len;

  logic                     wdata_valid;
  logic [7:0]               wdata;
  logic                     wdata_ready;

  logic                     rdata_valid;
  logic [7:0]               rdata;
  logic                     rdata_ready;

  logic                     busy;

  logic [AW-1:0]            reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic                     reg_addrvalid;
  logic                     reg_write;
  logic [7:0]               write_data;
  logic                     reg_read;
  logic [7:0]               read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata,
    input  rdata_ready,
    output busy,
    output reg_address, reg_bytecnt, reg_addrvalid, reg_write, write_data, reg_read,
    input  read_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata,
    output rdata_ready,
    input  busy,
    input  reg_address, reg_bytecnt, reg_addrvalid, reg_write, write_data, reg_read,
    output read_data
  );

endinterface

// File: rtl/cw305_reg_master_rbuf.sv
// rtl/cw305_reg_master_rbuf.sv - single-entry read-byte holding buffer with valid/ready output
module cw305_reg_master_rbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tvalid,
  output logic [7:0] tdata,
  input  logic       tready
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && tready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tvalid = valid_q;
  assign tdata  = data_q;

endmodule

// File: rtl/cw305_reg_master.sv
// rtl/cw305_reg_master.sv - CW305 byte-serial register-bus initiator; CW_REG_MASTER_STATS_EN adds
// saturating traffic counters
module cw305_reg_master
  import cw305_reg_master_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 8,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                    usb_clk,
  input  logic                    reset_i,
`ifdef CW_REG_MASTER_STATS_EN
  input  logic                    stat_clear,
  output logic [STAT_BYTES_W-1:0] stat_wr_bytes,
  output logic [STAT_BYTES_W-1:0] stat_rd_bytes,
  output logic [STAT_CMDS_W-1:0]  stat_cmds,
`endif
  cw305_reg_master_if.master      bus
);

  localparam int AW  = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int LAT = (pREAD_LATENCY < READ_LAT_MIN) ? READ_LAT_MIN :
                       (pREAD_LATENCY > READ_LAT_MAX) ? READ_LAT_MAX : pREAD_LATENCY;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LAT - 1);

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [pBYTECNT_SIZE-1:0] len_q, len_d;
  logic [pBYTECNT_SIZE-1:0] idx_q, idx_d;
  logic                     av_q, av_d;
  logic [LAT_CNT_W-1:0]     lat_q, lat_d;

  logic cmd_ready, wdata_ready, reg_write, reg_read, busy;
  logic rbuf_load, rdata_valid, rd_hs, cmd_acc;

  assign rd_hs   = rdata_valid & bus.rdata_ready;
  assign cmd_acc = cmd_ready & bus.cmd_valid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    av_d        = av_q;
    lat_d       = lat_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    reg_write   = 1'b0;
    reg_read    = 1'b0;
    rbuf_load   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          idx_d   = '0;
          av_d    = 1'b1;
          state_d = bus.cmd_write ? ST_WRITE : ST_RREQ;
        end
      end
      ST_WRITE: begin
        wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          reg_write = 1'b1;
          if (idx_q == len_q) begin
            av_d    = 1'b0;
            state_d = ST_GAP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_RREQ: begin
        reg_read = 1'b1;
        lat_d    = '0;
        state_d  = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (lat_q == LAT_LAST) begin
          rbuf_load = 1'b1;
          state_d   = ST_RHOLD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_RHOLD: begin
        // Next reg_read waits for the held byte to drain, so the buffer never overruns.
        if (rd_hs) begin
          if (idx_q == len_q) begin
            av_d    = 1'b0;
            state_d = ST_GAP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RREQ;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        av_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      av_q    <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      av_q    <= av_d;
      lat_q   <= lat_d;
    end
  end

  cw305_reg_master_rbuf u_rbuf (
    .clk       (usb_clk),
    .rst       (reset_i),
    .load      (rbuf_load),
    .load_data (bus.read_data),
    .tvalid    (rdata_valid),
    .tdata     (bus.rdata),
    .tready    (bus.rdata_ready)
  );

  assign bus.cmd_ready     = cmd_ready;
  assign bus.wdata_ready   = wdata_ready;
  assign bus.rdata_valid   = rdata_valid;
  assign bus.busy          = busy;
  assign bus.reg_address   = addr_q;
  assign bus.reg_bytecnt   = idx_q;
  assign bus.reg_addrvalid = av_q;
  assign bus.reg_write     = reg_write;
  assign bus.write_data    = reg_write ? bus.wdata : 8'h00;
  assign bus.reg_read      = reg_read;

`ifdef CW_REG_MASTER_STATS_EN
  logic [STAT_BYTES_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [STAT_CMDS_W-1:0]  cmd_cnt_q, cmd_cnt_d;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    cmd_cnt_d = cmd_cnt_q;
    if (stat_clear) begin
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      cmd_cnt_d = '0;
    end else begin
      if (reg_write && (wr_cnt_q != '1)) wr_cnt_d  = wr_cnt_q + 1'b1;
      if (rd_hs && (rd_cnt_q != '1))     rd_cnt_d  = rd_cnt_q + 1'b1;
      if (cmd_acc && (cmd_cnt_q != '1))  cmd_cnt_d = cmd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  assign stat_wr_bytes = wr_cnt_q;
  assign stat_rd_bytes = rd_cnt_q;
  assign stat_cmds     = cmd_cnt_q;
`endif

endmodule
